// File: rtl/spi_poll_scheduler.sv
// Periodic slot scheduler for a shared SPI transaction engine: one round-robin
// grant per slot, START/DONE handshake, hung-engine timeout and overrun flag.
module spi_poll_scheduler #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned PERIOD  = 5000000,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_spi_start,
  input  logic             i_spi_done,
  output logic             o_slot_tick,
  output logic             o_timeout_err,
  output logic             o_overrun
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win_idx;
  logic               w_tick;
  logic               w_found;
  logic [PTR_W-1:0]   w_win_idx;
  int unsigned        w_idx;

  assign w_tick = (r_cnt == CNT_W'(PERIOD - 1));

  // Free-running slot counter; ENABLE deliberately has no effect here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      o_slot_tick <= 1'b0;
    end else begin
      r_cnt       <= w_tick ? '0 : r_cnt + CNT_W'(1);
      o_slot_tick <= w_tick;
    end
  end

  // Round-robin search: walk downward so the nearest requester after r_ptr wins.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = r_ptr;
    w_idx     = 0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      w_idx = (int'(r_ptr) + i) % N_REQ;
      if (|(i_req & (N_REQ'(1) << w_idx))) begin
        w_found   = 1'b1;
        w_win_idx = PTR_W'(w_idx);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_ptr         <= PTR_W'(N_REQ - 1);
      r_win_idx     <= '0;
      o_gnt         <= '0;
      o_spi_start   <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_spi_start   <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overrun     <= w_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_tick && i_enable && w_found) begin
            r_win_idx <= w_win_idx;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          o_gnt   <= N_REQ'(1) << r_win_idx;
          r_state <= S_START;
        end
        S_START: begin
          o_spi_start <= 1'b1;
          r_to_cnt    <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (i_spi_done) begin
            r_state <= S_RELEASE;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            o_timeout_err <= 1'b1;
            r_state       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          o_gnt   <= '0;
          r_ptr   <= r_win_idx;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
